// File: rtl/store_merge_ctrl_if.sv
// Store-path bundle between the control unit, the store merge controller and memory.
// The slave side is the controller; the master side is the requester plus memory.
interface store_merge_ctrl_if;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        error;

    modport slave (
        input  start,
        input  size,
        input  addr,
        input  wdata,
        input  mem_rdata,
        output mem_addr,
        output mem_wr,
        output mem_wdata,
        output busy,
        output done,
        output error
    );

    modport master (
        output start,
        output size,
        output addr,
        output wdata,
        output mem_rdata,
        input  mem_addr,
        input  mem_wr,
        input  mem_wdata,
        input  busy,
        input  done,
        input  error
    );
endinterface

// File: rtl/store_merge_ctrl.sv
// Sub-word store controller: read-modify-write for sh/sb, direct write for sw,
// single-cycle error completion for misaligned or reserved-size requests.
module store_merge_ctrl #(
    parameter int unsigned READ_WAIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    store_merge_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [2:0] WAIT_LAST = READ_WAIT[2:0];

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [2:0]  r_wait;
    logic        w_accept;
    logic        w_illegal;
    logic        w_read_last;
    logic [31:0] w_merged;

    function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (sz)
            SZ_WORD: bad = (off != 2'b00);
            SZ_HALF: bad = off[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian lane replacement on top of the captured memory word.
    function automatic logic [31:0] merge_word(input logic [1:0]  sz,
                                               input logic [1:0]  off,
                                               input logic [31:0] src,
                                               input logic [31:0] base);
        logic [31:0] m;
        m = base;
        case (sz)
            SZ_BYTE: begin
                case (off)
                    2'd0:    m[7:0]   = src[7:0];
                    2'd1:    m[15:8]  = src[7:0];
                    2'd2:    m[23:16] = src[7:0];
                    default: m[31:24] = src[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) m[31:16] = src[15:0];
                else        m[15:0]  = src[15:0];
            end
            default: m = src;
        endcase
        return m;
    endfunction

    assign w_accept    = (r_state == S_IDLE) && bus.start;
    assign w_illegal   = is_illegal(bus.size, bus.addr[1:0]);
    assign w_read_last = (r_wait == WAIT_LAST);
    assign w_merged    = merge_word(r_size, r_off, r_wdata, r_rdata);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_illegal)                 w_next = S_ERR;
                    else if (bus.size == SZ_WORD)  w_next = S_WRITE;
                    else                           w_next = S_READ;
                end
            end
            S_READ:  if (w_read_last) w_next = S_WRITE;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_size      <= 2'b00;
            r_off       <= 2'b00;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_wait      <= 3'd0;
        end else begin
            if (w_accept) begin
                r_size  <= bus.size;
                r_off   <= bus.addr[1:0];
                r_wdata <= bus.wdata;
                r_wait  <= 3'd0;
                // An erroring request never reaches memory, so the bus address holds.
                if (!w_illegal) r_mem_addr <= {bus.addr[31:2], 2'b00};
            end
            if (r_state == S_READ) begin
                if (w_read_last) r_rdata <= bus.mem_rdata;
                else             r_wait  <= r_wait + 3'd1;
            end
            if (r_state == S_WRITE) r_mem_wdata <= w_merged;
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wr    = (r_state == S_WRITE);
    assign bus.mem_wdata = (r_state == S_WRITE) ? w_merged : r_mem_wdata;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE) || (r_state == S_ERR);
    assign bus.error     = (r_state == S_ERR);

endmodule

// File: tb/tb_store_merge_ctrl.sv
// Randomized bench for store_merge_ctrl against a per-cycle expectation model
// derived from the store latency and byte-lane merge rules.
module tb_store_merge_ctrl;

    localparam int RW = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    store_merge_ctrl_if bus ();

    store_merge_ctrl #(.READ_WAIT(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT: 64 words, indexed by address bits [7:2].
    logic [31:0] mem [64];
    logic        mem_ready = 1'b0;
    int          wcount    = 0;
    logic [31:0] last_wa   = 32'd0;
    logic [31:0] last_wd   = 32'd0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h11223344;
        if (i == 8) return 32'hDEADC0DE;
        return (32'h9E3779B9 * (32'(i) + 32'd1)) ^ 32'h5A5A0F0F;
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (bus.mem_wr) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            wcount  <= wcount + 1;
            last_wa <= bus.mem_addr;
            last_wd <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    typedef struct packed {
        logic        busy;
        logic        wr;
        logic        done;
        logic        err;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    logic [31:0] exp_mem [64];
    logic [31:0] h_addr  = 32'd0;
    logic [31:0] h_wdata = 32'd0;
    int          errors  = 0;
    int          checks  = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic bit req_legal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b0;
        if (sz == 2'd0 && a[1:0] != 2'd0) return 1'b0;
        if (sz == 2'd1 && a[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [1:0] sz, input logic [31:0] a,
                                              input logic [31:0] d, input logic [31:0] old);
        int          sh;
        logic [31:0] mask;
        if (sz == 2'd0) return d;
        if (sz == 2'd2) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'h000000FF << sh;
        end else begin
            sh   = 16 * int'(a[1]);
            mask = 32'h0000FFFF << sh;
        end
        return (old & ~mask) | ((d << sh) & mask);
    endfunction

    // Expected output for every cycle of one accepted request, in order.
    task automatic model_push(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] al;
        logic [31:0] m;
        if (!req_legal(sz, a)) begin
            q.push_back('{1'b1, 1'b0, 1'b1, 1'b1, h_addr, h_wdata});
            return;
        end
        al = {a[31:2], 2'b00};
        m  = ref_merge(sz, a, d, exp_mem[a[7:2]]);
        if (sz != 2'd0)
            for (int i = 0; i <= RW; i++) q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, al, h_wdata});
        q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, al, m});
        q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, al, m});
        h_addr  = al;
        h_wdata = m;
    endtask

    task automatic cmp_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset)            e = '0;
            else if (q.size() > 0) e = q.pop_front();
            else                   e = '{1'b0, 1'b0, 1'b0, 1'b0, h_addr, h_wdata};
            chk("cycle busy/wr/done/err/addr/wdata",
                {28'd0, bus.busy, bus.mem_wr, bus.done, bus.error, bus.mem_addr, bus.mem_wdata},
                {28'd0, e});
            if (reset && e.wr) exp_mem[e.a[7:2]] = e.d;
        end
    endtask

    task automatic drive_start(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.size  = sz;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        model_push(sz, a, d);
        #1;
        bus.start = 1'b0;
        bus.size  = 2'($urandom);
        bus.addr  = $urandom;
        bus.wdata = $urandom;
    endtask

    task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input bit poke, output int lat, output logic err);
        drive_start(sz, a, d);
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = poke && ($urandom_range(0, 1) == 1);
        end
        bus.start = 1'b0;
        err = bus.error;
        if (!bus.done) chk("done_timeout", {95'd0, bus.done}, 96'd1);
    endtask

    task automatic abort(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input int n);
        int w0;
        drive_start(sz, a, d);
        w0 = wcount;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        h_addr  = 32'd0;
        h_wdata = 32'd0;
        #1;
        chk("abort_outputs",
            {28'd0, bus.busy, bus.mem_wr, bus.done, bus.error, bus.mem_addr, bus.mem_wdata}, 96'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        chk("abort_writes", 96'(wcount - w0), 96'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion required finish within time limit");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic        err;
        int          w0;
        int          bad;
        logic [1:0]  sz;
        logic [31:0] a;
        bus.start = 1'b0;
        bus.size  = 2'b00;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
        for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
        fork
            cmp_loop();
        join_none
        #1 reset = 1'b0;
        #1;
        chk("reset_state",
            {28'd0, bus.busy, bus.mem_wr, bus.done, bus.error, bus.mem_addr, bus.mem_wdata}, 96'd0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;

        w0 = wcount;
        issue(2'd2, 32'h00000013, 32'h000000AB, 1'b0, lat, err);
        chk("sb_latency", 96'(lat), 96'd4);
        chk("sb_waddr", 96'(last_wa), 96'h10);
        chk("sb_wdata", 96'(last_wd), 96'hAB223344);
        chk("sb_writes", 96'(wcount - w0), 96'd1);

        w0 = wcount;
        issue(2'd1, 32'h00000022, 32'h1234BEEF, 1'b0, lat, err);
        chk("sh_latency", 96'(lat), 96'd4);
        chk("sh_error", {95'd0, err}, 96'd0);
        chk("sh_waddr", 96'(last_wa), 96'h20);
        chk("sh_wdata", 96'(last_wd), 96'hBEEFC0DE);
        chk("sh_writes", 96'(wcount - w0), 96'd1);

        w0 = wcount;
        issue(2'd0, 32'h00000040, 32'hCAFEBABE, 1'b0, lat, err);
        chk("sw_latency", 96'(lat), 96'd2);
        chk("sw_waddr", 96'(last_wa), 96'h40);
        chk("sw_wdata", 96'(last_wd), 96'hCAFEBABE);
        chk("sw_writes", 96'(wcount - w0), 96'd1);

        w0 = wcount;
        issue(2'd1, 32'h00000021, 32'h11111111, 1'b0, lat, err);
        chk("err_sh_latency", 96'(lat), 96'd1);
        chk("err_sh_flag", {95'd0, err}, 96'd1);
        issue(2'd0, 32'h00000042, 32'h22222222, 1'b0, lat, err);
        chk("err_sw_latency", 96'(lat), 96'd1);
        chk("err_sw_flag", {95'd0, err}, 96'd1);
        issue(2'd3, 32'h00000050, 32'h33333333, 1'b0, lat, err);
        chk("err_rsv_latency", 96'(lat), 96'd1);
        chk("err_rsv_flag", {95'd0, err}, 96'd1);
        chk("err_writes", 96'(wcount - w0), 96'd0);

        w0 = wcount;
        issue(2'd1, 32'h00000030, 32'h0000A5A5, 1'b1, lat, err);
        chk("poke_writes", 96'(wcount - w0), 96'd1);
        chk("poke_latency", 96'(lat), 96'(RW + 3));

        abort(2'd2, 32'h00000013, 32'h00000055, 0);
        w0 = wcount;
        issue(2'd2, 32'h00000013, 32'h000000CD, 1'b0, lat, err);
        chk("after_abort_latency", 96'(lat), 96'd4);
        chk("after_abort_wdata", 96'(last_wd), 96'hCD223344);
        chk("after_abort_writes", 96'(wcount - w0), 96'd1);
        abort(2'd0, 32'h00000044, 32'h12345678, 0);

        for (int it = 0; it < 250; it++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd0) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0]   = 1'b0;
            end
            if ($urandom_range(0, 19) == 0)
                abort(sz, a, $urandom, (sz == 2'd1 || sz == 2'd2) ? $urandom_range(0, RW + 1) : 0);
            else begin
                issue(sz, a, $urandom, $urandom_range(0, 2) == 0, lat, err);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk("final_memory_words_differing", 96'(bad), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_merge_ctrl.md
STORE_MERGE_CTRL -- requirements
Module: store_merge_ctrl

Interface
REQ-001 Parameter READ_WAIT, default 1, memory read wait cycles after the address is presented (legal 0..7).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  store request strobe from the control unit, sampled in IDLE only.
REQ-005 size  input  2  store size: 00 word (sw), 01 halfword (sh), 10 byte (sb), 11 reserved.
REQ-006 addr  input  32  byte address of the store.
REQ-007 wdata  input  32  store source (register B value); sb uses [7:0], sh uses [15:0].
REQ-008 mem_addr  output  32  word-aligned memory address.
REQ-009 mem_wr  output  1  memory write enable.
REQ-010 mem_wdata  output  32  merged word driven to memory.
REQ-011 mem_rdata  input  32  memory read data.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 error  output  1  one-cycle misaligned/reserved-size pulse, coincident with done.

Function
REQ-015 States SHALL be IDLE, READ, WRITE, DONE, ERR; encoding is free.
REQ-016 In IDLE with start=1, addr, size and wdata SHALL be latched at that rising edge, and the request SHALL be checked.
REQ-017 A request SHALL be illegal when size=11, size=00 with addr[1:0]!=00, or size=01 with addr[0]=1; an illegal request goes IDLE->ERR.
REQ-018 Legal word store SHALL go IDLE->WRITE; legal sh/sb SHALL go IDLE->READ.
REQ-019 READ SHALL last exactly READ_WAIT+1 cycles (wait counter); mem_addr={addr[31:2],2'b00}, mem_wr=0.
REQ-020 mem_rdata SHALL be captured into an internal word register on the final rising edge of READ, then READ->WRITE.
REQ-021 Byte lanes are little-endian: lane n = bits [8n+7:8n] at byte offset n.
REQ-022 Merge: sb replaces lane addr[1:0] with wdata[7:0]; sh replaces [15:0] (addr[1]=0) or [31:16] (addr[1]=1) with wdata[15:0]; other lanes SHALL keep captured values; sw uses wdata unchanged.
REQ-023 WRITE SHALL last one cycle: mem_wr=1, mem_addr aligned, mem_wdata=merged word; then WRITE->DONE.
REQ-024 DONE: done=1 for one cycle, error=0, then ->IDLE.
REQ-025 ERR: done=1 and error=1 for one cycle, mem_wr=0 throughout, then ->IDLE.
REQ-026 mem_wr SHALL be 1 only in WRITE; at most one write per request.
REQ-027 start while busy=1 SHALL be ignored, with no queuing.
REQ-028 Latency from start edge to done high: sw 2 cycles; sh/sb READ_WAIT+3 cycles; error 1 cycle.
REQ-029 Outside READ/WRITE, mem_addr and mem_wdata SHALL hold their last values (0 after reset).
REQ-030 start may be reasserted in the cycle after DONE/ERR and SHALL be accepted.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, with mem_wr=0, done=0, error=0, busy=0, mem_addr=0, mem_wdata=0, and the wait counter and captured word cleared.
REQ-032 Reset asserted mid-operation SHALL abort the request with no mem_wr pulse, even if the block was in WRITE.
REQ-033 After reset deasserts, the first rising edge SHALL see IDLE.

Verification
REQ-034 sb, addr=0x00000013, wdata=0x000000AB, memory[0x10]=0x11223344, READ_WAIT=1 -> single write 0xAB223344 at 0x10, done 4 cycles after start.
REQ-035 sh, addr=0x00000022, wdata=0x1234BEEF, memory[0x20]=0xDEADC0DE -> write 0xBEEFC0DE at 0x20, error=0.
REQ-036 sw, addr=0x00000040, wdata=0xCAFEBABE -> no READ, one write 0xCAFEBABE at 0x40, done 2 cycles after start.
REQ-037 sh addr=0x21, then sw addr=0x42, then size=11 -> each gives done=error=1 one cycle after start, mem_wr never 1.
REQ-038 sb started, reset=0 during READ -> all outputs 0 immediately, no write; a new sb after release completes normally.
REQ-039 start pulsed while busy during an sh -> ignored, exactly one write, one done pulse.
